// File: rtl/instr_encoder_if.sv
// Field-bundle handshake and imem write port for instr_encoder.
// slave is the encoder side; master is the loader/imem side.
interface instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [1:0]        in_class;
  logic [3:0]        in_cond;
  logic [3:0]        in_cmd;
  logic              in_i;
  logic              in_s;
  logic              in_l;
  logic [3:0]        in_rn;
  logic [3:0]        in_rd;
  logic [3:0]        in_rm;
  logic [23:0]       in_imm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              mem_ready;

  modport slave (
    input  in_valid, in_last, in_class, in_cond, in_cmd,
    input  in_i, in_s, in_l, in_rn, in_rd, in_rm, in_imm,
    input  mem_ready,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_last, in_class, in_cond, in_cmd,
    output in_i, in_s, in_l, in_rn, in_rd, in_rm, in_imm,
    output mem_ready,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic DP/MEM/B fields into ARM words and streams them to imem.
// Define IMM_ROTATE_EN to encode DP immediates > 255 as rotated imm8.
module instr_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  instr_encoder_if.slave    b,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, FULL
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DEPTH-1);

  state_t            state, nxt;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic [31:0]       enc;
  logic              rej;
  logic              accept, fire, cnt_hit;
  logic              cls_dp, cls_mem, cls_br;
  logic              cmd_ok, is_cmp;
  logic              dp_imm_ok;
  logic [11:0]       dp_imm, src2;

  assign b.wr_en   = wen;
  assign b.wr_addr = waddr;
  assign b.wr_data = wdata;

  assign b.in_ready = (state == RUN) & ~start
                    & (~wen | b.mem_ready);
  assign accept  = b.in_valid & b.in_ready;
  assign fire    = wen & b.mem_ready;
  assign cnt_hit = word_cnt == LAST_CNT;
  assign busy    = state == RUN;

  assign cls_dp  = b.in_class == 2'b00;
  assign cls_mem = b.in_class == 2'b01;
  assign cls_br  = b.in_class == 2'b10;
  assign is_cmp  = b.in_cmd == 4'b1010;

  always_comb begin
    case (b.in_cmd)
      4'b0100, 4'b0010, 4'b0000,
      4'b1100, 4'b1010: cmd_ok = 1'b1;
      default:          cmd_ok = 1'b0;
    endcase
  end

`ifdef IMM_ROTATE_EN
  logic [31:0] imm32, rolv;
  logic [3:0]  rot;
  logic [7:0]  imm8;

  // Scan high to low so the smallest fitting rotation wins.
  always_comb begin
    imm32     = {8'h00, b.in_imm};
    rolv      = '0;
    rot       = '0;
    imm8      = '0;
    dp_imm_ok = 1'b0;
    for (int k = 15; k >= 0; k--) begin
      rolv = (imm32 << (2*k)) | (imm32 >> (32 - 2*k));
      if (rolv[31:8] == 24'h0) begin
        dp_imm_ok = 1'b1;
        rot       = 4'(k);
        imm8      = rolv[7:0];
      end
    end
  end
  assign dp_imm = {rot, imm8};
`else
  assign dp_imm_ok = b.in_imm[23:8] == 16'h0;
  assign dp_imm    = {4'h0, b.in_imm[7:0]};
`endif

  assign src2 = b.in_i ? dp_imm : {8'h00, b.in_rm};

  always_comb begin
    enc = '0;
    rej = 1'b0;
    unique case (1'b1)
      cls_dp: begin
        rej = ~cmd_ok | (b.in_i & ~dp_imm_ok);
        enc = {b.in_cond, 2'b00, b.in_i, b.in_cmd,
               b.in_s | is_cmp, b.in_rn,
               is_cmp ? 4'h0 : b.in_rd, src2};
      end
      cls_mem: begin
        rej = |b.in_imm[23:12];
        enc = {b.in_cond, 2'b01, 4'b0110, 1'b0,
               b.in_l, b.in_rn, b.in_rd,
               b.in_imm[11:0]};
      end
      cls_br: begin
        enc = {b.in_cond, 3'b101, 1'b0, b.in_imm};
      end
      default: rej = 1'b1;
    endcase
  end

  always_comb begin
    nxt = state;
    if (start) begin
      nxt = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (fire & cnt_hit)
            nxt = FULL;
          else if (accept & b.in_last)
            nxt = DRAIN;
        end
        DRAIN: if (~wen | b.mem_ready) nxt = IDLE;
        default: nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wen      <= 1'b0;
      waddr    <= BASE;
      wdata    <= '0;
      word_cnt <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      wen      <= 1'b0;
      waddr    <= BASE;
      word_cnt <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == DRAIN) & (nxt == IDLE);
      if (fire) begin
        waddr    <= waddr + 1'b1;
        word_cnt <= word_cnt + 1'b1;
      end
      if (accept & ~rej) begin
        wen   <= 1'b1;
        wdata <= enc;
      end else if (accept | fire) begin
        wen <= 1'b0;
      end
      if (accept & rej) err <= 1'b1;
      // Anything accepted alongside the DEPTH-th write is dropped.
      if (state == RUN && nxt == FULL) begin
        wen <= 1'b0;
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table + scoreboard,
// plus stall, reject, FULL and mid-stream reset sequences.
module tb_instr_encoder;

  typedef struct {
    logic [1:0]  cls;
    logic [3:0]  cond, cmd;
    logic        i, s, l;
    logic [3:0]  rn, rd, rm;
    logic [23:0] imm;
    logic        last;
    logic        rej;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, start, start2;
  logic       busy, done, err;
  logic       busy2, done2, err2;
  logic [6:0] word_cnt, cnt2;

  int   checks = 0;
  int   failures = 0;
  int   exp_addr = 0;
  int   wr2 = 0;
  exp_t sbq[$];
  vec_t vt[16];

  instr_encoder_if #(.ADDR_W(6)) e ();
  instr_encoder_if #(.ADDR_W(6)) e2 ();

  instr_encoder #(.ADDR_W(6), .BASE_ADDR(0), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .b(e),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  instr_encoder #(.ADDR_W(6), .BASE_ADDR(0), .DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .b(e2),
    .busy(busy2), .done(done2), .err(err2), .word_cnt(cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] cls, input logic [3:0] cond,
    input logic [3:0] cmd, input logic i, input logic s,
    input logic l, input logic [3:0] rn, input logic [3:0] rd,
    input logic [3:0] rm, input logic [23:0] imm,
    input logic last, input logic rej, input logic [31:0] word);
    vec_t v;
    v.cls = cls; v.cond = cond; v.cmd = cmd;
    v.i = i; v.s = s; v.l = l;
    v.rn = rn; v.rd = rd; v.rm = rm; v.imm = imm;
    v.last = last; v.rej = rej; v.word = word;
    return v;
  endfunction

  // Scoreboard: every imem write must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && e.wr_en && e.mem_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_write", {26'h0, e.wr_addr}, 32'hFFFF_FFFF);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        chk("sb_addr", {26'h0, e.wr_addr}, {26'h0, x.a});
        chk("sb_data", e.wr_data, x.d);
      end
    end
  end

  always @(negedge clk)
    if (!reset && e2.wr_en && e2.mem_ready) wr2++;

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = 0;
  endtask

  task automatic send(input vec_t v, output int waits);
    e.in_valid = 1'b1;
    e.in_class = v.cls; e.in_cond = v.cond; e.in_cmd = v.cmd;
    e.in_i = v.i; e.in_s = v.s; e.in_l = v.l;
    e.in_rn = v.rn; e.in_rd = v.rd; e.in_rm = v.rm;
    e.in_imm = v.imm; e.in_last = v.last;
    waits = 0;
    @(negedge clk);
    while (!e.in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!e.in_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end else if (!v.rej) begin
      sbq.push_back('{6'(exp_addr), v.word});
      exp_addr++;
    end
    @(posedge clk); #1;
    e.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int cnt, input logic exp_err);
    int n = 0;
    @(negedge clk);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1'b1);
    chk("done_cnt", 32'(word_cnt), cnt);
    chk("done_addr", {26'h0, e.wr_addr}, 32'(6'(cnt)));
    chk("done_err", err, exp_err);
    chk("done_idle", busy, 1'b0);
    chk("sb_empty", sbq.size(), 0);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
  endtask

  initial begin
    int w;
    int acc2;
    logic prog_rej;

    vt[0]  = mk(2'd0, 4'hE, 4'h4, 1, 0, 0, 4'd2, 4'd1, 4'd0,
                24'h5, 1, 0, 32'hE282_1005);
    vt[1]  = mk(2'd0, 4'hE, 4'h2, 0, 1, 0, 4'd4, 4'd3, 4'd5,
                24'h0, 0, 0, 32'hE054_3005);
    vt[2]  = mk(2'd1, 4'hE, 4'h0, 0, 0, 1, 4'd1, 4'd0, 4'd0,
                24'h8, 0, 0, 32'hE591_0008);
    vt[3]  = mk(2'd1, 4'hE, 4'h0, 0, 0, 0, 4'd3, 4'd2, 4'd0,
                24'h4, 0, 0, 32'hE583_2004);
    vt[4]  = mk(2'd2, 4'hE, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0,
                24'h10, 0, 0, 32'hEA00_0010);
    vt[5]  = mk(2'd0, 4'h0, 4'hA, 0, 0, 0, 4'd6, 4'd7, 4'd9,
                24'h0, 0, 0, 32'h0156_0009);
    vt[6]  = mk(2'd0, 4'h1, 4'hC, 1, 0, 0, 4'hF, 4'hE, 4'd3,
                24'hFF, 0, 0, 32'h138F_E0FF);
    vt[7]  = mk(2'd1, 4'hE, 4'h0, 0, 0, 1, 4'd6, 4'd5, 4'd0,
                24'hFFF, 0, 0, 32'hE596_5FFF);
    vt[8]  = mk(2'd2, 4'hB, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0,
                24'hFFFFFE, 0, 0, 32'hBAFF_FFFE);
    vt[9]  = mk(2'd0, 4'hE, 4'h0, 0, 0, 0, 4'd1, 4'd2, 4'd3,
                24'h123, 1, 0, 32'hE001_2003);
`ifdef IMM_ROTATE_EN
    vt[10] = mk(2'd0, 4'hE, 4'h4, 1, 0, 0, 4'd2, 4'd1, 4'd0,
                24'h100, 0, 0, 32'hE282_1C01);
`else
    vt[10] = mk(2'd0, 4'hE, 4'h4, 1, 0, 0, 4'd2, 4'd1, 4'd0,
                24'h100, 0, 1, 32'h0);
`endif
    vt[11] = mk(2'd1, 4'hE, 4'h0, 0, 0, 1, 4'd1, 4'd0, 4'd0,
                24'h1000, 0, 1, 32'h0);
    vt[12] = mk(2'd0, 4'hE, 4'h1, 0, 0, 0, 4'd1, 4'd2, 4'd3,
                24'h0, 0, 1, 32'h0);
    vt[13] = mk(2'd0, 4'hE, 4'h4, 1, 0, 0, 4'd2, 4'd1, 4'd0,
                24'h101, 0, 1, 32'h0);
    vt[14] = mk(2'd2, 4'hE, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0,
                24'h20, 0, 0, 32'hEA00_0020);
    vt[15] = mk(2'd3, 4'hE, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0,
                24'h0, 1, 1, 32'h0);

    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    e.in_valid = 1'b0; e.in_last = 1'b0; e.in_class = '0;
    e.in_cond = '0; e.in_cmd = '0; e.in_i = 1'b0; e.in_s = 1'b0;
    e.in_l = 1'b0; e.in_rn = '0; e.in_rd = '0; e.in_rm = '0;
    e.in_imm = '0; e.mem_ready = 1'b1;
    e2.in_valid = 1'b0; e2.in_last = 1'b0; e2.in_class = 2'd0;
    e2.in_cond = 4'hE; e2.in_cmd = 4'h4; e2.in_i = 1'b1;
    e2.in_s = 1'b0; e2.in_l = 1'b0; e2.in_rn = 4'd1;
    e2.in_rd = 4'd1; e2.in_rm = 4'd0; e2.in_imm = 24'h1;
    e2.mem_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", e.in_ready, 1'b0);
    chk("rst_wr_en", e.wr_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_addr", {26'h0, e.wr_addr}, 32'h0);
    chk("rst_data", e.wr_data, 32'h0);
    chk("rst_cnt", 32'(word_cnt), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    prog_rej = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || vt[i-1].last) begin
        do_start();
        prog_rej = 1'b0;
      end
      send(vt[i], w);
      chk("ready_hold", w, 0);
      if (vt[i].rej) prog_rej = 1'b1;
      if (vt[i].last) wait_done(exp_addr, prog_rej);
    end

    // Stall: held CMP word must stay put while imem is not ready.
    do_start();
    e.mem_ready = 1'b0;
    send(mk(2'd0, 4'hE, 4'hA, 1, 0, 0, 4'd1, 4'd0, 4'd0,
            24'h0, 0, 0, 32'hE351_0000), w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_wr_en", e.wr_en, 1'b1);
      chk("stall_data", e.wr_data, 32'hE351_0000);
      chk("stall_in_ready", e.in_ready, 1'b0);
      chk("stall_addr", {26'h0, e.wr_addr}, 32'h0);
      @(posedge clk); #1;
    end
    e.mem_ready = 1'b1;
    send(mk(2'd2, 4'hE, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0,
            24'h7, 1, 0, 32'hEA00_0007), w);
    chk("stall_release_wait", w, 0);
    wait_done(2, 1'b0);

    // DEPTH=4 instance: fifth bundle must never reach imem.
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    acc2 = 0;
    e2.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (e2.in_ready) acc2++;
      @(posedge clk); #1;
    end
    e2.in_valid = 1'b0;
    @(negedge clk);
    chk("full_accepts", acc2, 5);
    chk("full_in_ready", e2.in_ready, 1'b0);
    chk("full_err", err2, 1'b1);
    chk("full_busy", busy2, 1'b0);
    chk("full_cnt", 32'(cnt2), 32'd4);
    chk("full_addr", {26'h0, e2.wr_addr}, 32'd4);
    chk("full_wr_en", e2.wr_en, 1'b0);
    repeat (2) @(negedge clk);
    chk("full_writes", wr2, 4);
    chk("full_stays", e2.in_ready, 1'b0);
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(negedge clk);
    chk("restart_busy", busy2, 1'b1);
    chk("restart_err", err2, 1'b0);
    chk("restart_cnt", 32'(cnt2), 32'd0);
    @(posedge clk); #1;

    // Reset with a word pending discards it.
    do_start();
    send(vt[4], w);
    send(vt[2], w);
    e.mem_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_cnt", 32'(word_cnt), 32'd1);
    chk("pre_rst_wr_en", e.wr_en, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sbq.delete();
    exp_addr = 0;
    @(negedge clk);
    chk("mid_rst_wr_en", e.wr_en, 1'b0);
    chk("mid_rst_addr", {26'h0, e.wr_addr}, 32'h0);
    chk("mid_rst_cnt", 32'(word_cnt), 32'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", e.in_ready, 1'b0);
    e.mem_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

endmodule
